// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXE    = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EXE    = 4'd10,
      S_I_WB     = 4'd11,
      S_HALT     = 4'd15
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_SLT   = 2'b11;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // States that wait on mem_ready_i and are guarded by the timeout counter.
   function automatic logic is_wait_state(state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts stalled cycles of a memory access; flags expiry on the last allowed cycle.
module multicycle_ctrl_mem_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic wait_i,
   input  logic ready_i,
   output logic expire_o
);

   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q;

   // Clear on any state change, count each stalled cycle in a wait state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                  cnt_q <= '0;
      else if (clr_i)              cnt_q <= '0;
      else if (wait_i && !ready_i) cnt_q <= cnt_q + 1'b1;
   end

   // Ready on the final cycle still completes the access, so expiry needs !ready.
   assign expire_o = wait_i && !ready_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS-subset datapath.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       instr_op_i,
   input  logic             mem_ready_i,
   input  logic             zero_i,
   output logic             PCWrite_o,
   output logic             PCWriteCond_o,
   output logic             BranchNe_o,
   output logic             IorD_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             IRWrite_o,
   output logic             MemtoReg_o,
   output logic             RegDst_o,
   output logic             RegWrite_o,
   output logic             ALUSrcA_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [1:0]       ALUOp_o,
   output logic [1:0]       PCSource_o,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired_o,
   output logic             halted_o,
   output logic [1:0]       err_code_o
);

   state_e           state_q, state_d;
   logic [1:0]       err_q, err_d;
   logic [CNT_W-1:0] retired_q;
   logic             expire, retire;
   ctrl_t            ctrl, ctrl_gated;

   // Branch resolution is gated in the datapath; the flag is not needed here.
   logic unused_zero;
   assign unused_zero = zero_i;

   multicycle_ctrl_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (state_d != state_q),
      .wait_i   (is_wait_state(state_q)),
      .ready_i  (mem_ready_i),
      .expire_o (expire)
   );

   // Next-state and error-code selection.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready_i) state_d = S_DECODE;
            else if (expire) begin state_d = S_HALT; err_d = ERR_TIMEOUT; end
         end
         S_DECODE: begin
            case (instr_op_i)
               OP_RTYPE:       state_d = S_R_EXE;
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:           state_d = S_JUMP;
               OP_ADDI, OP_SLTI: state_d = S_I_EXE;
               default: begin state_d = S_HALT; err_d = ERR_ILLEGAL; end
            endcase
         end
         S_MEM_ADDR: begin
            if (instr_op_i == OP_LW)      state_d = S_MEM_RD;
            else if (instr_op_i == OP_SW) state_d = S_MEM_WR;
            else begin state_d = S_HALT; err_d = ERR_ILLEGAL; end
         end
         S_MEM_RD: begin
            if (mem_ready_i) state_d = S_MEM_WB;
            else if (expire) begin state_d = S_HALT; err_d = ERR_TIMEOUT; end
         end
         S_MEM_WR: begin
            if (mem_ready_i) state_d = S_FETCH;
            else if (expire) begin state_d = S_HALT; err_d = ERR_TIMEOUT; end
         end
         S_R_EXE: state_d = S_R_WB;
         S_I_EXE: state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: begin state_d = S_HALT; err_d = ERR_ILLEGAL; end
      endcase
   end

   // Every path back to FETCH comes from a final state, so that edge retires.
   assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

   // State, sticky error code and retired-instruction counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_FETCH;
         err_q     <= ERR_NONE;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (retire) retired_q <= retired_q + 1'b1;
      end
   end

   // Control decode from the registered state; fetch strobes wait for ready.
   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready_i;
            ctrl.pc_write  = mem_ready_i;
         end
         S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH;
         S_MEM_ADDR: begin ctrl.alu_src_a = 1'b1; ctrl.alu_src_b = SRCB_IMM; end
         S_MEM_RD:   begin ctrl.mem_read = 1'b1; ctrl.iord = 1'b1; end
         S_MEM_WB:   begin ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; end
         S_MEM_WR:   begin ctrl.mem_write = 1'b1; ctrl.iord = 1'b1; end
         S_R_EXE:    begin ctrl.alu_src_a = 1'b1; ctrl.alu_op = ALUOP_FUNCT; end
         S_R_WB:     begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
            ctrl.branch_ne     = (instr_op_i == OP_BNE);
         end
         S_JUMP:  begin ctrl.pc_write = 1'b1; ctrl.pc_source = PCSRC_JUMP; end
         S_I_EXE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = (instr_op_i == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
         end
         S_I_WB:  ctrl.reg_write = 1'b1;
         default: ctrl = '0;
      endcase
   end

   // Reset overrides the decode immediately, without waiting for a clock.
   assign ctrl_gated = rst_i ? ctrl : '0;

   assign PCWrite_o     = ctrl_gated.pc_write;
   assign PCWriteCond_o = ctrl_gated.pc_write_cond;
   assign BranchNe_o    = ctrl_gated.branch_ne;
   assign IorD_o        = ctrl_gated.iord;
   assign MemRead_o     = ctrl_gated.mem_read;
   assign MemWrite_o    = ctrl_gated.mem_write;
   assign IRWrite_o     = ctrl_gated.ir_write;
   assign MemtoReg_o    = ctrl_gated.mem_to_reg;
   assign RegDst_o      = ctrl_gated.reg_dst;
   assign RegWrite_o    = ctrl_gated.reg_write;
   assign ALUSrcA_o     = ctrl_gated.alu_src_a;
   assign ALUSrcB_o     = ctrl_gated.alu_src_b;
   assign ALUOp_o       = ctrl_gated.alu_op;
   assign PCSource_o    = ctrl_gated.pc_source;
   assign state_o       = state_q;
   assign retired_o     = retired_q;
   assign halted_o      = (state_q == S_HALT);
   assign err_code_o    = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for the multi-cycle control FSM.
module tb_multicycle_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [5:0]  instr_op_i = '0;
   logic        mem_ready_i = 1'b0;
   logic        zero_i = 1'b0;
   logic        PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o;
   logic        IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
   logic [1:0]  ALUSrcB_o, ALUOp_o, PCSource_o;
   logic [3:0]  state_o;
   logic [31:0] retired_o;
   logic        halted_o;
   logic [1:0]  err_code_o;

   always #5 clk_i = ~clk_i;

   multicycle_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i),
      .mem_ready_i(mem_ready_i), .zero_i(zero_i),
      .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .BranchNe_o(BranchNe_o),
      .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .IRWrite_o(IRWrite_o), .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o),
      .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
      .ALUOp_o(ALUOp_o), .PCSource_o(PCSource_o), .state_o(state_o),
      .retired_o(retired_o), .halted_o(halted_o), .err_code_o(err_code_o)
   );

   // {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
   //  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[2], ALUOp[2], PCSource[2]}
   logic [16:0] ctl;
   assign ctl = {PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o,
                 IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
                 ALUSrcB_o, ALUOp_o, PCSource_o};

   localparam logic [16:0] C_FETCH_R = 17'b1_0_0_0_1_0_1_0_0_0_0_01_00_00;
   localparam logic [16:0] C_FETCH_W = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_00;
   localparam logic [16:0] C_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
   localparam logic [16:0] C_MADDR   = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [16:0] C_MRD     = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
   localparam logic [16:0] C_MWB     = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
   localparam logic [16:0] C_MWR     = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
   localparam logic [16:0] C_REXE    = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
   localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
   localparam logic [16:0] C_BNE     = 17'b0_1_1_0_0_0_0_0_0_0_1_00_01_01;
   localparam logic [16:0] C_BEQ     = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
   localparam logic [16:0] C_JMP     = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
   localparam logic [16:0] C_IADD    = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [16:0] C_ISLT    = 17'b0_0_0_0_0_0_0_0_0_0_1_10_11_00;
   localparam logic [16:0] C_IWB     = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_00;

   typedef struct {
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [16:0] ctl;
      int          ret;
   } vec_t;

   vec_t tv[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [16:0] c, input int ret);
      vec_t v;
      v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.ret = ret;
      tv.push_back(v);
   endtask

   // Drive just after a rising edge, check on the falling edge, step to next cycle.
   task automatic row(input string tag, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [16:0] c, input int ret);
      instr_op_i  = op;
      mem_ready_i = rdy;
      @(negedge clk_i);
      chk({tag, " state"},   32'(state_o),   32'(st));
      chk({tag, " ctl"},     32'(ctl),       32'(c));
      chk({tag, " retired"}, retired_o,      32'(ret));
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i       = 1'b0;
      mem_ready_i = 1'b1;
      instr_op_i  = 6'h00;
      #1;
      chk("rst state",   32'(state_o),    32'd0);
      chk("rst ctl",     32'(ctl),        32'd0);
      chk("rst retired", retired_o,       32'd0);
      chk("rst err",     32'(err_code_o), 32'd0);
      chk("rst halted",  32'(halted_o),   32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // ---- one instruction of every class, ready mostly high ----
      add(6'h00, 1, 0, C_FETCH_R, 0);  add(6'h00, 1, 1, C_DEC, 0);
      add(6'h00, 1, 6, C_REXE, 0);     add(6'h00, 1, 7, C_RWB, 0);
      add(6'h23, 1, 0, C_FETCH_R, 1);  add(6'h23, 1, 1, C_DEC, 1);
      add(6'h23, 1, 2, C_MADDR, 1);
      add(6'h23, 0, 3, C_MRD, 1);      add(6'h23, 0, 3, C_MRD, 1);
      add(6'h23, 0, 3, C_MRD, 1);      add(6'h23, 1, 3, C_MRD, 1);
      add(6'h23, 1, 4, C_MWB, 1);
      add(6'h2B, 0, 0, C_FETCH_W, 2);  add(6'h2B, 1, 0, C_FETCH_R, 2);
      add(6'h2B, 1, 1, C_DEC, 2);      add(6'h2B, 1, 2, C_MADDR, 2);
      add(6'h2B, 1, 5, C_MWR, 2);
      add(6'h05, 1, 0, C_FETCH_R, 3);  add(6'h05, 1, 1, C_DEC, 3);
      add(6'h05, 1, 8, C_BNE, 3);
      add(6'h04, 1, 0, C_FETCH_R, 4);  add(6'h04, 1, 1, C_DEC, 4);
      add(6'h04, 1, 8, C_BEQ, 4);
      add(6'h02, 1, 0, C_FETCH_R, 5);  add(6'h02, 1, 1, C_DEC, 5);
      add(6'h02, 1, 9, C_JMP, 5);
      add(6'h08, 1, 0, C_FETCH_R, 6);  add(6'h08, 1, 1, C_DEC, 6);
      add(6'h08, 1, 10, C_IADD, 6);    add(6'h08, 1, 11, C_IWB, 6);
      add(6'h0A, 1, 0, C_FETCH_R, 7);  add(6'h0A, 1, 1, C_DEC, 7);
      add(6'h0A, 1, 10, C_ISLT, 7);    add(6'h0A, 1, 11, C_IWB, 7);
      add(6'h00, 0, 0, C_FETCH_W, 8);

      zero_i = 1'b0;
      do_reset();
      for (int i = 0; i < tv.size(); i++)
         row($sformatf("v%0d", i), tv[i].op, tv[i].rdy, tv[i].st, tv[i].ctl, tv[i].ret);

      // ---- illegal opcode after one jump: sticky HALT ----
      do_reset();
      row("ill f", 6'h02, 1, 0, C_FETCH_R, 0);
      row("ill d", 6'h02, 1, 1, C_DEC, 0);
      row("ill j", 6'h02, 1, 9, C_JMP, 0);
      row("ill f2", 6'h3F, 1, 0, C_FETCH_R, 1);
      row("ill d2", 6'h3F, 1, 1, C_DEC, 1);
      for (int i = 0; i < 20; i++) begin
         mem_ready_i = i[0];
         instr_op_i  = (i < 10) ? 6'h00 : 6'h23;
         @(negedge clk_i);
         chk($sformatf("ill halt st %0d", i), 32'(state_o), 32'd15);
         chk($sformatf("ill halt ctl %0d", i), 32'(ctl), 32'd0);
         chk($sformatf("ill halted %0d", i), 32'(halted_o), 32'd1);
         chk($sformatf("ill err %0d", i), 32'(err_code_o), 32'd1);
         chk($sformatf("ill retired %0d", i), retired_o, 32'd1);
         @(posedge clk_i);
         #1;
      end

      // ---- FETCH timeout: 16 stalled cycles then HALT ----
      do_reset();
      for (int i = 0; i < 16; i++)
         row($sformatf("to f%0d", i), 6'h00, 0, 0, C_FETCH_W, 0);
      @(negedge clk_i);
      chk("to state",  32'(state_o),    32'd15);
      chk("to err",    32'(err_code_o), 32'd2);
      chk("to halted", 32'(halted_o),   32'd1);
      @(posedge clk_i);
      #1;

      // ---- ready on the 16th FETCH cycle wins over timeout ----
      do_reset();
      for (int i = 0; i < 15; i++)
         row($sformatf("rw f%0d", i), 6'h00, 0, 0, C_FETCH_W, 0);
      row("rw f15", 6'h00, 1, 0, C_FETCH_R, 0);
      @(negedge clk_i);
      chk("rw state", 32'(state_o),    32'd1);
      chk("rw err",   32'(err_code_o), 32'd0);
      @(posedge clk_i);
      #1;

      // ---- MEM_RD timeout; counter restarts after a stalled fetch ----
      do_reset();
      for (int i = 0; i < 5; i++)
         row($sformatf("rt f%0d", i), 6'h23, 0, 0, C_FETCH_W, 0);
      row("rt f5", 6'h23, 1, 0, C_FETCH_R, 0);
      row("rt d",  6'h23, 1, 1, C_DEC, 0);
      row("rt a",  6'h23, 1, 2, C_MADDR, 0);
      for (int i = 0; i < 16; i++)
         row($sformatf("rt r%0d", i), 6'h23, 0, 3, C_MRD, 0);
      @(negedge clk_i);
      chk("rt state", 32'(state_o),    32'd15);
      chk("rt err",   32'(err_code_o), 32'd2);
      @(posedge clk_i);
      #1;

      // ---- asynchronous reset in the middle of MEM_WR ----
      do_reset();
      row("mr f",  6'h00, 1, 0, C_FETCH_R, 0);
      row("mr d",  6'h00, 1, 1, C_DEC, 0);
      row("mr e",  6'h00, 1, 6, C_REXE, 0);
      row("mr w",  6'h00, 1, 7, C_RWB, 0);
      row("mr f2", 6'h2B, 1, 0, C_FETCH_R, 1);
      row("mr d2", 6'h2B, 1, 1, C_DEC, 1);
      row("mr a2", 6'h2B, 1, 2, C_MADDR, 1);
      mem_ready_i = 1'b0;
      @(negedge clk_i);
      chk("mr memwrite pre", 32'(MemWrite_o), 32'd1);
      chk("mr state pre",    32'(state_o),    32'd5);
      #2 rst_i = 1'b0;
      #1;
      chk("mr memwrite async", 32'(MemWrite_o), 32'd0);
      chk("mr ctl async",      32'(ctl),        32'd0);
      chk("mr state async",    32'(state_o),    32'd0);
      chk("mr retired async",  retired_o,       32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      row("mr post", 6'h2B, 0, 0, C_FETCH_W, 0);
      row("mr post2", 6'h2B, 1, 0, C_FETCH_R, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS-subset datapath: PC, shared instruction/data memory, register file, ALU, sign-extender, shifter and PC-source mux.
- Replaces the single-cycle Decoder in the multi-cycle build.
- Takes opcode, memory ready and ALU zero as inputs, and drives all datapath enables and mux selects.
- Also keeps a retired-instruction counter, and halts on an illegal opcode or a memory timeout.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 16, max cycles any memory access may wait for mem_ready_i before bus error (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
instr_op_i  in  6  opcode field of instruction register
mem_ready_i  in  1  memory has completed current read/write this cycle
zero_i  in  1  ALU zero flag from branch compare
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load qualified by branch condition
BranchNe_o  out  1  1: branch condition is !zero (bne); 0: zero (beq)
IorD_o  out  1  memory address mux: 0 PC, 1 ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  instruction register load
MemtoReg_o  out  1  write-back select: 0 ALUOut, 1 MDR
RegDst_o  out  1  destination: 0 rt, 1 rd
RegWrite_o  out  1  register file write enable
ALUSrcA_o  out  1  0 PC, 1 rs data
ALUSrcB_o  out  2  00 rt data, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp_o  out  2  00 add, 01 sub, 10 use funct, 11 set-less-than
PCSource_o  out  2  00 ALU result, 01 ALUOut, 10 jump target
state_o  out  4  current state encoding (debug)
retired_o  out  CNT_W  instructions completed since reset
halted_o  out  1  FSM in HALT
err_code_o  out  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (rst_i=0, async): state=FETCH, retired_o=0, err_code_o=00, wait counter=0.
  - All control outputs are forced 0 while rst_i=0, overriding the state decode.
  - state_o=0, halted_o=0.
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BRANCH=8, JUMP=9, I_EXE=10, I_WB=11, HALT=15.
- Outputs are decoded from state only, except IRWrite, PCWrite and the memory exits, which are also qualified by mem_ready_i. Any output not listed for a state is 0.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=1 only in the cycle mem_ready_i=1; that cycle goes to DECODE. Otherwise FETCH is held.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> R_EXE
  - 0x23 (lw) / 0x2B (sw) -> MEM_ADDR
  - 0x04 (beq) / 0x05 (bne) -> BRANCH
  - 0x02 (j) -> JUMP
  - 0x08 (addi) / 0x0A (slti) -> I_EXE
  - any other opcode -> HALT with err_code=01
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD for lw, MEM_WR for sw (opcode is re-sampled from the stable IR).
- MEM_RD: MemRead=1, IorD=1. Waits for mem_ready_i, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH and retires.
- MEM_WR: MemWrite=1, IorD=1. Waits for mem_ready_i, then goes to FETCH and retires.
- R_EXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH and retires.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=(op==0x05). Goes to FETCH and retires. The PC update is done by datapath gating with zero_i; zero_i is otherwise unused here.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH and retires.
- I_EXE: ALUSrcA=1, ALUSrcB=10, ALUOp=00 for addi, 11 for slti. Goes to I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH and retires.
- Retire: retired_o increments by 1 on the transition into FETCH from a final state. It wraps modulo 2^CNT_W with no flag.
- Memory timeout:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle mem_ready_i=0 in those states.
  - When the counter reaches TIMEOUT-1 with mem_ready_i still 0, next state is HALT with err_code=10.
  - If mem_ready_i=1 on that same cycle, the access completes normally (ready wins).
- HALT: all controls 0, halted_o=1, retired_o frozen. Sticky; only rst_i exits.
- Reset mid-operation (e.g. in MEM_WR): outputs drop to 0 immediately (asynchronously). FSM resumes in FETCH on the first rising edge after rst_i rises. No partial write is reissued.

Decomposition:
- Shared package: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_SLTI), ALUOp and ALUSrcB/PCSource encodings, err codes.
- One natural sub-module: mem_wait_timer (counter, clear, expire output) instantiated once.

Test Plan:
- Reset, then `add`, with mem_ready_i=1 always: state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; retired_o=1 after 4 cycles.
- `lw` with mem_ready_i low for 3 cycles in MEM_RD: state 3 held 4 cycles, MemRead=IorD=1 throughout; state 4 has MemtoReg=1; retired increments once.
- `bne` with zero_i=0, then `beq` with zero_i=0: in state 8 BranchNe=1 then 0, PCWriteCond=1, PCSource=01, ALUOp=01 both times.
- Opcode 0x3F: DECODE -> HALT; halted_o=1, err_code_o=01, all controls 0 for 20 further cycles, retired_o unchanged.
- TIMEOUT=16, mem_ready_i held 0 in FETCH: HALT entered after exactly 16 FETCH cycles with err_code=10. Repeat with ready on cycle 16: DECODE reached, no error.
- Assert rst_i=0 mid MEM_WR: MemWrite_o falls without a clock edge. After release, first state is FETCH and retired_o=0.
